// File: rtl/rv32i_types.sv
// Shared rename-stage types: default register counts, physical register ID and
// the valid+ID handoff used between rename and commit.
package rv32i_types;

  localparam int NUM_PREGS_DEF = 64;
  localparam int NUM_AREGS_DEF = 32;
  localparam int PREG_W_DEF    = $clog2(NUM_PREGS_DEF);

  typedef logic [PREG_W_DEF-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    preg_t preg;
  } preg_req_t;

endpackage

// File: rtl/circ_ptr.sv
// Wrap-bit circular pointer: MSB distinguishes laps, low bits index storage.
// Reset beats load, load beats increment.
module circ_ptr #(
  parameter int               PTR_W   = 6,
  parameter logic [PTR_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [PTR_W-1:0] load_val_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Capacity is a power of two, so natural overflow of the full-width add wraps
  // the index and toggles the wrap bit together.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i)     ptr_d = load_val_i;
    else if (inc_i) ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= RST_VAL;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/free_list_param.sv
// Parametrised physical-register free list (circular FIFO of free preg IDs).
// Define FREE_LIST_FLUSH_EN to enable retire-head tracking and flush rollback.
module free_list_param
  import rv32i_types::*;
#(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int NUM_AREGS = NUM_AREGS_DEF,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   deq_req,
  output logic                   deq_ready,
  output logic [PREG_W-1:0]      deq_preg,
  input  logic                   enq_valid,
  input  logic [PREG_W-1:0]      enq_preg,
  input  logic                   commit_alloc,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow_err,
  output logic                   underflow_err
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW-1:0]     head_load_val;
  logic              head_load;
  logic              overflow_q, underflow_q;
  logic              empty, full;
  logic              enq_nonzero, enq_ok, deq_fire;

  assign count       = tail - head;
  assign empty       = (count == '0);
  assign full        = (count == PW'(DEPTH));
  assign deq_ready   = !empty;
  assign deq_preg    = mem_q[head[IW-1:0]];
  assign enq_nonzero = enq_valid && (enq_preg != '0);
  assign enq_ok      = enq_nonzero && !full;

`ifdef FREE_LIST_FLUSH_EN
  logic [PW-1:0] retire_head;
  logic          retire_inc;

  // Retire head may only catch up to head, never overtake it.
  assign retire_inc    = commit_alloc && !flush && (retire_head != head);
  assign head_load     = flush;
  assign head_load_val = retire_head + PW'(commit_alloc);
  assign deq_fire      = deq_req && deq_ready && !flush;

  circ_ptr #(.PTR_W(PW), .RST_VAL('0)) u_retire_ptr (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (retire_inc),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (retire_head)
  );
`else
  logic unused_flush_sigs;

  assign unused_flush_sigs = commit_alloc ^ flush;
  assign head_load         = 1'b0;
  assign head_load_val     = '0;
  assign deq_fire          = deq_req && deq_ready;
`endif

  circ_ptr #(.PTR_W(PW), .RST_VAL('0)) u_head_ptr (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (deq_fire),
    .load_i     (head_load),
    .load_val_i (head_load_val),
    .ptr_o      (head)
  );

  // Tail starts one full lap ahead of head: the list begins full.
  circ_ptr #(.PTR_W(PW), .RST_VAL(PW'(DEPTH))) u_tail_ptr (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (enq_ok),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (tail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PREG_W'(NUM_AREGS + i);
    end else if (enq_ok) begin
      mem_q[tail[IW-1:0]] <= enq_preg;
    end
  end

  // Full is judged before this cycle's dequeue, so full+deq+enq still overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (enq_nonzero && full) overflow_q  <= 1'b1;
      if (deq_req && empty)    underflow_q <= 1'b1;
    end
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_free_list_param.sv
// Directed bench for free_list_param with default parameters (64 pregs, 32 aregs).
module tb_free_list_param;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         deq_req, enq_valid, commit_alloc, flush;
  logic [W-1:0] enq_preg;
  logic         deq_ready, overflow_err, underflow_err;
  logic [W-1:0] deq_preg;
  logic [5:0]   count;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  free_list_param dut (
    .clk           (clk),
    .rst           (rst),
    .deq_req       (deq_req),
    .deq_ready     (deq_ready),
    .deq_preg      (deq_preg),
    .enq_valid     (enq_valid),
    .enq_preg      (enq_preg),
    .commit_alloc  (commit_alloc),
    .flush         (flush),
    .count         (count),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock with the given inputs held; returns #1 after the edge with inputs idle.
  task automatic cycle(input logic d, input logic e, input logic [W-1:0] p,
                       input logic ca, input logic fl);
    deq_req = d; enq_valid = e; enq_preg = p; commit_alloc = ca; flush = fl;
    @(posedge clk);
    #1;
    deq_req = 0; enq_valid = 0; enq_preg = '0; commit_alloc = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle(0, 0, '0, 0, 0);
    rst = 0;
  endtask

  task automatic deq_n(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, 0);
  endtask

  initial begin
    rst = 0; deq_req = 0; enq_valid = 0; enq_preg = '0; commit_alloc = 0; flush = 0;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    check("rst_count", count, 32);
    check("rst_ready", deq_ready, 1);
    check("rst_preg", deq_preg, 32);
    check("rst_ovf", overflow_err, 0);
    check("rst_unf", underflow_err, 0);

    // Drain in order
    for (int i = 0; i < 32; i++) begin
      check("drain_ready", deq_ready, 1);
      check("drain_preg", deq_preg, 32 + i);
      cycle(1, 0, '0, 0, 0);
    end
    check("drain_ready_end", deq_ready, 0);
    check("drain_count_end", count, 0);
    check("drain_unf", underflow_err, 0);

    // Empty with deq + enq: no bypass
    cycle(1, 1, 6'd5, 0, 0);
    check("empty_unf", underflow_err, 1);
    check("empty_count", count, 1);
    check("empty_ready", deq_ready, 1);
    check("empty_preg", deq_preg, 5);
    check("empty_ovf", overflow_err, 0);

    // Overflow from full
    do_reset();
    check("rst2_unf", underflow_err, 0);
    cycle(0, 1, 6'd7, 0, 0);
    check("ovf_flag", overflow_err, 1);
    check("ovf_count", count, 32);
    check("ovf_preg", deq_preg, 32);
    cycle(1, 0, '0, 0, 0);
    check("ovf_next_preg", deq_preg, 33);
    check("ovf_count2", count, 31);

    // Full with simultaneous deq + enq still flags overflow, enqueue dropped
    do_reset();
    cycle(1, 1, 6'd9, 0, 0);
    check("fulldq_ovf", overflow_err, 1);
    check("fulldq_count", count, 31);

    // x0 is never freed
    do_reset();
    deq_n(22);
    check("zero_pre_count", count, 10);
    cycle(0, 1, 6'd0, 0, 0);
    check("zero_count", count, 10);
    check("zero_ovf", overflow_err, 0);
    check("zero_unf", underflow_err, 0);

    // Steady state at 16 with wrap-around
    do_reset();
    deq_n(16);
    check("steady_pre_count", count, 16);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(W'(48 + i));
    for (int i = 0; i < 100; i++) begin
      logic [W-1:0] id;
      logic [W-1:0] want;
      id = W'(1 + (i % 63));
      want = exp_q.pop_front();
      check("steady_preg", deq_preg, want);
      exp_q.push_back(id);
      cycle(1, 1, id, 0, 0);
      check("steady_count", count, 16);
    end
    check("steady_ovf", overflow_err, 0);
    check("steady_unf", underflow_err, 0);

`ifdef FREE_LIST_FLUSH_EN
    // Rollback to the retire head
    do_reset();
    deq_n(5);
    check("flush_pre_count", count, 27);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(1, 0, '0, 0, 1);
    check("flush_count", count, 30);
    check("flush_preg", deq_preg, 34);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule
